// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, prefetch FIFO handing {pc, instr} to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushes counters.

// Generic FIFO with synchronous clear; head is valid whenever o_empty is low.
module fetch_fifo #(
   parameter int               WIDTH   = 64,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_clr,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_dat,
   input  logic                         i_pop,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [WIDTH-1:0]             o_head_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] w_ents [DEPTH];
   logic             w_pop;

   assign w_pop      = i_pop && (r_count != '0);
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_head_dat = w_ents[r_rd_ptr];

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [WIDTH-1:0] r_ent;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ent <= RST_VAL;
         end else if (i_push && !i_clr && (r_wr_ptr == AW'(g))) begin
            r_ent <= i_push_dat;
         end
      end
      assign w_ents[g] = r_ent;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushes
`endif
);
   localparam int          CW      = $clog2(FIFO_DEPTH+1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic          r_run;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_rsp_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop;

   logic [CW-1:0] w_occ;
   logic          w_empty;
   logic [63:0]   w_head;
   logic          w_accept;
   logic          w_rsp_drop;
   logic          w_push;
   logic          w_pop;
   logic [CW:0]   w_credit;
   logic [CW-1:0] w_inflight_nxt;
   logic [31:0]   w_redir_pc;

   assign w_redir_pc = {redirect_pc[31:2], 2'b00};

   assign id_valid          = !w_empty;
   assign {id_pc, id_instr} = w_head;

   assign w_pop      = id_valid && id_ready && !redirect_valid;
   assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
   assign w_push     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

   // Slots freed by this cycle's pop or dropped word are reused at once, so a
   // single-cycle memory with id_ready high sustains one word per cycle.
   assign w_credit = ({1'b0, r_inflight} + {1'b0, w_occ})
                   - {{CW{1'b0}}, w_pop} - {{CW{1'b0}}, w_rsp_drop};

   assign imem_req_valid = r_run && !redirect_valid && (w_credit < DEPTH_W);
   assign imem_req_addr  = r_fetch_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   assign w_inflight_nxt = r_inflight + {{(CW-1){1'b0}}, w_accept}
                                      - {{(CW-1){1'b0}}, imem_rsp_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run      <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= w_inflight_nxt;
         if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_rsp_pc   <= w_redir_pc;
            // Everything still outstanding after this cycle belongs to the old stream.
            r_drop     <= w_inflight_nxt;
         end else begin
            if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
            if (w_rsp_drop) r_drop     <= r_drop - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .WIDTH   (64),
      .DEPTH   (FIFO_DEPTH),
      .RST_VAL ({RESET_PC, NOP})
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (redirect_valid),
      .i_push     (w_push),
      .i_push_dat ({r_rsp_pc, imem_rsp_data}),
      .i_pop      (w_pop),
      .o_empty    (w_empty),
      .o_count    (w_occ),
      .o_head_dat (w_head)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_flushes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= '0;
         r_perf_flushes <= '0;
      end else begin
         if (w_pop)          r_perf_fetched <= r_perf_fetched + 32'd1;
         if (redirect_valid) r_perf_flushes <= r_perf_flushes + 32'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_flushes = r_perf_flushes;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model plus {pc, instr} scoreboard.
module tb_fetch_unit;
   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushes;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushes   (perf_flushes)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   req_t        mem_q[$];
   exp_t        sb[$];
   logic [31:0] del_pcs[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          mem_lat = 1;
   int          n_acc = 0;
   int          n_del = 0;
   int          first_acc = -1;
   int          first_del = -1;
   int          base;
   logic [31:0] exp_fpc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h0000_1013;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory response, sample at negedge, update model.
   task automatic step(input logic redir, input logic [31:0] rpc);
      req_t r;
      exp_t e;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         r = mem_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(r.addr);
         if (r.epoch == epoch && !redir)
            sb.push_back('{pc: r.addr, instr: mem_word(r.addr)});
      end
      @(negedge clk);
      if (redir) check("req_valid_in_redirect", imem_req_valid, 0);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_fpc);
      if (imem_req_valid && imem_req_ready) begin
         mem_q.push_back('{addr: exp_fpc, due: cyc + mem_lat, epoch: epoch});
         exp_fpc = exp_fpc + 32'd4;
         n_acc++;
         if (first_acc < 0) first_acc = cyc;
      end
      if (id_valid && !id_ready && !redir && sb.size() > 0)
         check("id_head_hold", {id_pc, id_instr}, {sb[0].pc, sb[0].instr});
      if (id_valid && id_ready && !redir) begin
         check("id_expected_present", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("id_word", {id_pc, id_instr}, {e.pc, e.instr});
         end
         del_pcs.push_back(id_pc);
         n_del++;
         if (first_del < 0) first_del = cyc;
      end
      if (redir) begin
         sb.delete();
         epoch++;
         exp_fpc = {rpc[31:2], 2'b00};
      end
      check("credit_bound", (mem_q.size() + sb.size()) <= DEPTH, 1);
      @(posedge clk);
      #1;
      cyc++;
      redirect_valid = 1'b0;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr", imem_req_addr, RPC);
      check("rst_id_valid", id_valid, 0);
      check("rst_id_instr", id_instr, 32'h0000_0013);
      check("rst_id_pc", id_pc, RPC);
`ifdef FETCH_PERF_EN
      check("rst_perf_fetched", perf_fetched, 0);
      check("rst_perf_flushes", perf_flushes, 0);
`endif
      mem_q.delete();
      sb.delete();
      epoch++;
      exp_fpc        = RPC;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc += 2;
      first_acc = -1;
      first_del = -1;
      check("first_req_valid", imem_req_valid, 1);
      check("first_req_addr", imem_req_addr, RPC);
   endtask

   task automatic wait_deliveries(input string tag, input int n, input int budget);
      int start;
      start = n_del;
      for (int i = 0; i < budget && (n_del - start) < n; i++) step(1'b0, '0);
      check(tag, (n_del - start) >= n, 1);
   endtask

   initial begin
      rst_n          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      exp_fpc        = RPC;
      #1;
      reset_dut();

      // Streaming with single-cycle memory
      del_pcs.delete();
      base = n_del;
      for (int i = 0; i < 12; i++) step(1'b0, '0);
      check("first_id_latency", first_del - first_acc, 2);
      check("stream_count", n_del - base, 10);
      check("first_id_pc", del_pcs[0], 32'h0000_0000);

      // Decode stall
      id_ready = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, '0);
      check("stall_req_valid", imem_req_valid, 0);
      check("stall_id_valid", id_valid, 1);
      check("stall_buffered", sb.size(), DEPTH);
      id_ready = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, '0);

      // Redirect with two requests in flight, 3-cycle memory
      mem_lat = 3;
      for (int i = 0; i < 6; i++) step(1'b0, '0);
      for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1'b0, '0);
      check("two_in_flight", mem_q.size(), 2);
      step(1'b1, 32'h0000_1002);
      check("id_valid_after_redirect", id_valid, 0);
      del_pcs.delete();
      wait_deliveries("wait_redirect_1000", 1, 30);
      check("redirect_pc_1000", del_pcs[0], 32'h0000_1000);

      // Back-to-back redirects: the last wins
      step(1'b1, 32'h0000_3000);
      step(1'b1, 32'h0000_4006);
      check("id_valid_after_b2b", id_valid, 0);
      del_pcs.delete();
      wait_deliveries("wait_redirect_4004", 1, 30);
      check("redirect_pc_4004", del_pcs[0], 32'h0000_4004);

      // Redirect coinciding with an id handshake and a response arrival
      mem_lat = 1;
      for (int i = 0; i < 30 && !(mem_q.size() > 0 && mem_q[0].due <= cyc
                                  && mem_q[0].epoch == epoch && sb.size() > 0); i++)
         step(1'b0, '0);
      check("collision_setup", sb.size() > 0, 1);
      step(1'b1, 32'h0000_2000);
      imem_req_ready = 1'b0;
      id_ready       = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, '0);
      check("collision_id_valid", id_valid, 0);
      check("collision_drained", mem_q.size(), 0);
      check("collision_req_valid", imem_req_valid, 1);
      imem_req_ready = 1'b1;
      base = n_acc;
      for (int i = 0; i < 5; i++) step(1'b0, '0);
      check("credit_refill", n_acc - base, DEPTH);
      check("collision_head_pc", id_pc, 32'h0000_2000);
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, '0);

      // Address wrap
      step(1'b1, 32'hFFFF_FFF8);
      del_pcs.delete();
      wait_deliveries("wait_wrap", 3, 40);
      check("wrap_pc0", del_pcs[0], 32'hFFFF_FFF8);
      check("wrap_pc1", del_pcs[1], 32'hFFFF_FFFC);
      check("wrap_pc2", del_pcs[2], 32'h0000_0000);

      // Counted deliveries and redirects, then reset mid-run
      reset_dut();
      base = n_del;
      for (int i = 0; i < 15; i++) begin
         id_ready = ((n_del - base) < 5);
         step(1'b0, '0);
      end
      check("delivered_five", n_del - base, 5);
      id_ready = 1'b0;
      step(1'b1, 32'h0000_0100);
      step(1'b0, '0);
      step(1'b1, 32'h0000_0200);
      for (int i = 0; i < 4; i++) step(1'b0, '0);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, 5);
      check("perf_flushes", perf_flushes, 2);
`endif
      check("pre_reset_id_valid", id_valid, 1);
      reset_dut();
      for (int i = 0; i < 4; i++) step(1'b0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
